// File: rtl/div_pkg.sv
// Shared definitions for the multi-cycle DIV/DIVU divider: FSM encoding,
// iteration count and HI/LO field positions of the 64-bit result.
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_ITER  = 32;
  localparam int CNT_W     = $clog2(DIV_ITER);

  localparam int HI_MSB = 63;
  localparam int HI_LSB = 32;
  localparam int LO_MSB = 31;

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    BY_ZERO = 2'd1,
    ON      = 2'd2,
    END     = 2'd3
  } div_state_e;

  function automatic logic [DIV_WIDTH-1:0] magnitude(input logic [DIV_WIDTH-1:0] v,
                                                     input logic                 neg);
    return neg ? -v : v;
  endfunction

endpackage

// File: rtl/div_if.sv
// Start/ready handshake between the EX stage (master) and the divider (slave).
interface div_if
  import div_pkg::*;
();

  logic                   start_i;
  logic                   annul_i;
  logic                   signed_i;
  logic [DIV_WIDTH-1:0]   opa_i;
  logic [DIV_WIDTH-1:0]   opb_i;
  logic [2*DIV_WIDTH-1:0] result_o;
  logic                   ready_o;
  logic                   busy_o;

  modport master (
    output start_i, annul_i, signed_i, opa_i, opb_i,
    input  result_o, ready_o, busy_o
  );

  modport slave (
    input  start_i, annul_i, signed_i, opa_i, opb_i,
    output result_o, ready_o, busy_o
  );

endinterface

// File: rtl/div_step.sv
// One radix-2 restoring iteration: trial-subtract the divisor magnitude from
// the shifted partial remainder and keep the difference if it did not borrow.
module div_step
  import div_pkg::*;
(
  input  logic [DIV_WIDTH:0]   part_rem,
  input  logic [DIV_WIDTH-1:0] divisor,
  output logic [DIV_WIDTH-1:0] rem_next,
  output logic                 q_bit
);

  // A kept difference is always below the divisor, so it fits in DIV_WIDTH bits.
  assign q_bit    = (part_rem >= {1'b0, divisor});
  assign rem_next = q_bit ? DIV_WIDTH'(part_rem - {1'b0, divisor})
                          : part_rem[DIV_WIDTH-1:0];

endmodule

// File: rtl/div_unit.sv
// Multi-cycle 32-bit divider for DIV/DIVU; result is {remainder, quotient}.
// Signed operation is built only when DIV_SIGNED_EN is defined.
module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH  // only 32 is supported
) (
  input  logic clk,
  input  logic rst_n,
  div_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV_ITER - 1);

  div_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   rem_q, dvd_q, dvs_q;
  logic [WIDTH-1:0]   rem_next, quo_next, fin_q, fin_r;
  logic [WIDTH-1:0]   opa_mag, opb_mag;
  logic [2*WIDTH-1:0] result_q;
  logic               q_bit, accept;

  assign accept = (state_q == FREE) && bus.start_i && !bus.annul_i;

  // The dividend register shifts out dividend bits MSB first while quotient bits fill in at the LSB.
  div_step u_step (
    .part_rem ({rem_q, dvd_q[WIDTH-1]}),
    .divisor  (dvs_q),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  assign quo_next = {dvd_q[WIDTH-2:0], q_bit};

`ifdef DIV_SIGNED_EN
  logic sign_a, sign_b, neg_q_q, neg_r_q;

  assign sign_a  = bus.signed_i & bus.opa_i[WIDTH-1];
  assign sign_b  = bus.signed_i & bus.opb_i[WIDTH-1];
  assign opa_mag = magnitude(bus.opa_i, sign_a);
  assign opb_mag = magnitude(bus.opb_i, sign_b);
  assign fin_q   = neg_q_q ? -quo_next : quo_next;
  assign fin_r   = neg_r_q ? -rem_next : rem_next;
`else
  assign opa_mag = bus.opa_i;
  assign opb_mag = bus.opb_i;
  assign fin_q   = quo_next;
  assign fin_r   = rem_next;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FREE;
    else        state_q <= state_d;
  end

  // NOTE: every output of a combinational block gets a default first; a missed path would infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FREE:    if (accept) state_d = (bus.opb_i == '0) ? BY_ZERO : ON;
      BY_ZERO: state_d = bus.annul_i ? FREE : END;
      ON: begin
        if (bus.annul_i)        state_d = FREE;
        else if (cnt_q == LAST) state_d = END;
      end
      END:     if (bus.annul_i || !bus.start_i) state_d = FREE;
      default: state_d = FREE;
    endcase
  end

  always_comb begin
    bus.ready_o = 1'b0;
    bus.busy_o  = 1'b0;
    case (state_q)
      BY_ZERO, ON: bus.busy_o  = 1'b1;
      END:         bus.ready_o = 1'b1;
      default:     ;
    endcase
  end

  // NOTE: datapath registers are few and flops, not memory, so all take the async reset and
  //       a reset mid-divide clears result_o at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      result_q <= '0;
`ifdef DIV_SIGNED_EN
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        FREE: begin
          if (accept) begin
            dvd_q   <= opa_mag;
            dvs_q   <= opb_mag;
            rem_q   <= '0;
            cnt_q   <= '0;
`ifdef DIV_SIGNED_EN
            neg_q_q <= sign_a ^ sign_b;
            neg_r_q <= sign_a;
`endif
          end
        end
        ON: begin
          rem_q <= rem_next;
          dvd_q <= quo_next;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST && !bus.annul_i) begin
            result_q[HI_MSB:HI_LSB] <= fin_r;
            result_q[LO_MSB:0]      <= fin_q;
          end
        end
        BY_ZERO: if (!bus.annul_i) result_q <= '0;
        default: ;
      endcase
    end
  end

  assign bus.result_o = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed cases plus random divides compared
// against a plain-arithmetic reference; honours DIV_SIGNED_EN like the design.
module tb_div_unit;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;
  logic [63:0] last_exp = 64'd0;

  div_if bus ();

  div_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    assert (observed === expected) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, observed, expected);
  endtask

  // Reference: HI = remainder, LO = quotient, zero divisor yields zero; signed
  // results use truncating division with the remainder following the dividend.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    longint sa, sb, q, r;
    logic [31:0] uq, ur;
    if (b == 32'd0) return 64'd0;
`ifdef DIV_SIGNED_EN
    if (sgn) begin
      sa = longint'(signed'(a));
      sb = longint'(signed'(b));
      q  = sa / sb;
      r  = sa % sb;
      return {r[31:0], q[31:0]};
    end
`else
    sa = longint'(sgn);
`endif
    uq = a / b;
    ur = a % b;
    return {ur, uq};
  endfunction

  // Launch one divide, time ready_o from the accepting edge, hold start_i for
  // `hold` extra cycles, then release and confirm the return to FREE.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         input string tag, input int hold);
    logic [63:0] exp;
    int lat, cyc;
    bit seen;
    exp = ref_div(a, b, sgn);
    lat = (b == 32'd0) ? 2 : 33;
    @(negedge clk);
    bus.start_i  = 1'b1;
    bus.opa_i    = a;
    bus.opb_i    = b;
    bus.signed_i = sgn;
    @(posedge clk);
    #1;
    bus.opa_i = $urandom;
    bus.opb_i = $urandom;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) check({tag, " busy@1"}, 64'(bus.busy_o), 64'd1);
      if (bus.ready_o) seen = 1'b1;
    end
    check({tag, " latency"}, 64'(cyc), 64'(lat));
    check({tag, " result"}, bus.result_o, exp);
    check({tag, " busy@ready"}, 64'(bus.busy_o), 64'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, " hold ready+result"}, {bus.result_o[62:0], bus.ready_o}, {exp[62:0], 1'b1});
    end
    bus.start_i = 1'b0;
    @(negedge clk);
    check({tag, " free after drop"}, {62'd0, bus.ready_o, bus.busy_o}, 64'd0);
    last_exp = exp;
  endtask

  initial begin
    int seen_ready;
    logic [31:0] ra, rb;
    bus.start_i  = 1'b0;
    bus.annul_i  = 1'b0;
    bus.signed_i = 1'b0;
    bus.opa_i    = '0;
    bus.opb_i    = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset outputs", {bus.result_o[61:0], bus.ready_o, bus.busy_o}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases from the plan.
    run_div(32'd100, 32'd7, 1'b0, "u 100/7", 0);
    check("u 100/7 literal", last_exp, {32'h2, 32'hE});
    run_div(32'hFFFF_FFF9, 32'h2, 1'b1, "s -7/2", 0);
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "s min/-1", 0);
    run_div(32'd5, 32'd0, 1'b0, "zero div", 0);
    run_div(32'hFFFF_FFFF, 32'd1, 1'b0, "u max/1", 0);
    run_div(32'd3, 32'hFFFF_FFFF, 1'b0, "u small/max", 0);
    run_div(32'd1234567, 32'd89, 1'b0, "hold 5", 5);

    // start with annul in FREE: nothing starts.
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.annul_i = 1'b1;
    bus.opa_i   = 32'd50;
    bus.opb_i   = 32'd5;
    seen_ready  = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.busy_o || bus.ready_o) seen_ready++;
    end
    check("annul beats start", 64'(seen_ready), 64'd0);
    bus.start_i = 1'b0;
    bus.annul_i = 1'b0;

    // Abort at cycle 10 of ON.
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.opa_i   = 32'd100;
    bus.opb_i   = 32'd7;
    @(posedge clk);
    repeat (10) @(negedge clk);
    check("abort busy@10", 64'(bus.busy_o), 64'd1);
    bus.annul_i = 1'b1;
    bus.start_i = 1'b0;
    @(negedge clk);
    check("abort free", {62'd0, bus.ready_o, bus.busy_o}, 64'd0);
    check("abort result kept", bus.result_o, last_exp);
    bus.annul_i = 1'b0;
    seen_ready  = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.ready_o) seen_ready++;
    end
    check("abort never ready", 64'(seen_ready), 64'd0);
    run_div(32'd9, 32'd3, 1'b0, "after abort 9/3", 0);
    check("9/3 literal", last_exp, {32'd0, 32'd3});

    // Asynchronous reset at cycle 20 of a divide.
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.opa_i   = 32'd1000;
    bus.opb_i   = 32'd3;
    @(posedge clk);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("reset mid result", bus.result_o, 64'd0);
    check("reset mid flags", {62'd0, bus.ready_o, bus.busy_o}, 64'd0);
    bus.start_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("after reset free", {62'd0, bus.ready_o, bus.busy_o}, 64'd0);
    run_div(32'd1000, 32'd3, 1'b0, "after reset", 0);

    // Random divides against the reference model.
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = $urandom_range(1, 15);
        1:       rb = $urandom;
        2:       rb = $urandom >> $urandom_range(0, 31);
        default: rb = (i % 6 == 0) ? 32'd0 : $urandom;
      endcase
      if (i % 5 == 0) ra = ra >> $urandom_range(16, 31);
      run_div(ra, rb, 1'($urandom_range(0, 1)), $sformatf("rand%0d", i), $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle 32-bit integer divider serving the DIV/DIVU instructions of the MIPS32 core. It sits between the EX stage and the HI/LO register pair. It accepts operands with a start/ready handshake and iterates one quotient bit per cycle. It presents the 64-bit {remainder, quotient} result that EX forwards into the HI/LO write port, with HI = remainder and LO = quotient.

## Interface
- WIDTH, 32, operand width; only 32 is supported.
- clk  input  1  core clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start_i  input  1  request a division; held high by EX until ready_o is seen.
- annul_i  input  1  abort the current operation (exception or flush).
- signed_i  input  1  1 = DIV (signed), 0 = DIVU.
- opa_i  input  32  dividend; sampled only when a start is accepted.
- opb_i  input  32  divisor; sampled only when a start is accepted.
- result_o  output  64  [63:32] remainder (HI), [31:0] quotient (LO).
- ready_o  output  1  result_o valid.
- busy_o  output  1  operation in flight; EX stalls on it.

## Operation
- Reset values: state FREE; result_o = 0; ready_o = 0; busy_o = 0; counter = 0.
- State FREE
  - start_i=1 and annul_i=0: latch the operands.
  - If opb_i == 0, go to BY_ZERO; otherwise go to ON with counter = 0.
- State BY_ZERO: next state END with result = 0.
- State ON: radix-2 restoring step each cycle.
  - Partial remainder is 33 bits: shift left 1 and bring in the next dividend bit, MSB first.
  - Subtract the divisor magnitude. If the difference is non-negative, keep it and set quotient bit 1; otherwise restore and set 0.
  - After the 32nd step (counter == 31), apply sign fix-up and go to END.
- State END
  - ready_o = 1 and result_o holds the final value.
  - Stay in END while start_i = 1.
  - When start_i = 0, go to FREE; ready_o drops that same edge.
- annul_i = 1 in BY_ZERO, ON or END: next state FREE, ready_o = 0, result_o unchanged.
- start_i and annul_i both high in FREE: annul wins and no operation starts.
- start_i in any state other than FREE or END has no effect. The operand inputs are ignored after acceptance.
- Signed mode
  - Operands are converted to magnitudes at acceptance.
  - Quotient is negated when the operand signs differ.
  - Remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0 (wraps, no trap).
- busy_o = 1 in BY_ZERO and ON; 0 in FREE and END.
- Divide by zero returns HI = 0 and LO = 0. The architecture leaves this result undefined; we fix it at zero.

## Timing
- Start sampled at edge 0 with a nonzero divisor: ON during cycles 1–32, END and ready_o = 1 from cycle 33. That is 33 cycles from start to ready.
- Divisor zero: BY_ZERO in cycle 1, ready_o = 1 in cycle 2.
- result_o is registered and stable for the whole of END.
- A new start is accepted no earlier than the cycle after END exits to FREE, giving one idle cycle between back-to-back divides.
- Asynchronous reset mid-operation returns all outputs to their reset values immediately. No partial result is ever flagged ready.

## Configuration
- DIV_SIGNED_EN
  - Defined: signed_i is honoured, with magnitude conversion and sign fix-up as above.
  - Undefined: signed_i is ignored, every operation is unsigned, and the negation logic is not built.

## Structure
- Shared package div_pkg holds:
  - state encoding FREE/BY_ZERO/ON/END as a 2-bit typedef;
  - DIV_ITER = 32;
  - the result field positions (HI_MSB = 63, HI_LSB = 32, LO_MSB = 31).
- One sub-module, div_step: combinational single restoring iteration. Takes the 33-bit partial remainder and the divisor magnitude; returns the next remainder and the quotient bit. Instantiated once.

## Test plan
- Unsigned: 100 / 7 with signed_i = 0 → ready_o at cycle 33, result_o = {0x00000002, 0x0000000E}.
- Signed: −7 / 2 (0xFFFFFFF9 / 0x2) with signed_i = 1 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Also 0x80000000 / 0xFFFFFFFF → {0, 0x80000000}.
- Zero divisor: 5 / 0 → ready_o at cycle 2, result_o = 0. busy_o high only in cycle 1.
- Handshake: hold start_i for 5 extra cycles after ready_o → ready_o stays high and result_o stays stable. Drop start_i → FREE next edge.
- Abort: annul_i asserted at cycle 10 of ON → FREE next cycle, ready_o never asserts. The following 9 / 3 then completes normally with {0, 3}.
- Reset: rst_n pulsed low at cycle 20 of a divide → result_o, ready_o and busy_o are 0 immediately, and state is FREE after release.
